// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and widths for the RC4 phase sequencer
package rc4_pkg;

    localparam int KEY_WIDTH_DEF = 24;
    localparam int S_ADDR_W      = 8;
    localparam int S_DATA_W      = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_RUN,
        ST_INIT_GAP,
        ST_KSA_RUN,
        ST_KSA_GAP,
        ST_PRGA_RUN,
        ST_EVAL,
        ST_FOUND,
        ST_EXHAUSTED
    } state_t;

    typedef enum logic [1:0] {
        GR_NONE,
        GR_INIT,
        GR_KSA,
        GR_PRGA
    } grant_t;

    // Only RUN states own the S-RAM port; everything else parks it at zero.
    function automatic grant_t grant_of(input state_t s);
        case (s)
            ST_INIT_RUN: return GR_INIT;
            ST_KSA_RUN:  return GR_KSA;
            ST_PRGA_RUN: return GR_PRGA;
            default:     return GR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_phase_sequencer_s_mem_mux.sv
// rtl/rc4_phase_sequencer_s_mem_mux.sv - combinational 3:1 S-RAM port mux keyed by grant
module s_mem_mux
    import rc4_pkg::*;
(
    input  grant_t              grant,
    input  logic [S_ADDR_W-1:0] init_addr,
    input  logic [S_DATA_W-1:0] init_wdata,
    input  logic                init_wren,
    input  logic [S_ADDR_W-1:0] ksa_addr,
    input  logic [S_DATA_W-1:0] ksa_wdata,
    input  logic                ksa_wren,
    input  logic [S_ADDR_W-1:0] prga_addr,
    input  logic [S_DATA_W-1:0] prga_wdata,
    input  logic                prga_wren,
    output logic [S_ADDR_W-1:0] s_address,
    output logic [S_DATA_W-1:0] s_data,
    output logic                s_wren
);

    always_comb begin
        s_address = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        case (grant)
            GR_INIT: begin
                s_address = init_addr;
                s_data    = init_wdata;
                s_wren    = init_wren;
            end
            GR_KSA: begin
                s_address = ksa_addr;
                s_data    = ksa_wdata;
                s_wren    = ksa_wren;
            end
            GR_PRGA: begin
                s_address = prga_addr;
                s_data    = prga_wdata;
                s_wren    = prga_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// rtl/rc4_phase_sequencer.sv - sequences init/KSA/PRGA per candidate key and owns the S-RAM port
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 prga_start,
    input  logic                 init_done,
    input  logic                 ksa_done,
    input  logic                 prga_done,
    input  logic                 prga_ok,
    input  logic [S_ADDR_W-1:0]  init_addr,
    input  logic [S_ADDR_W-1:0]  ksa_addr,
    input  logic [S_ADDR_W-1:0]  prga_addr,
    input  logic [S_DATA_W-1:0]  init_wdata,
    input  logic [S_DATA_W-1:0]  ksa_wdata,
    input  logic [S_DATA_W-1:0]  prga_wdata,
    input  logic                 init_wren,
    input  logic                 ksa_wren,
    input  logic                 prga_wren,
    output logic [S_ADDR_W-1:0]  s_address,
    output logic [S_DATA_W-1:0]  s_data,
    output logic                 s_wren,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted
);

    state_t               state_q, state_d;
    grant_t               grant_q;
    logic [KEY_WIDTH-1:0] key_q;
    logic                 ok_q;
    logic                 found_q;
    logic                 exh_q;

    logic load_key, inc_key, latch_ok, clr_flags, set_found, set_exh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= GR_NONE;
            key_q   <= KEY_START;
            ok_q    <= 1'b0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_of(state_d);
            if (load_key) begin
                key_q <= KEY_START;
            end else if (inc_key) begin
                key_q <= key_q + KEY_WIDTH'(1);
            end
            if (latch_ok) begin
                ok_q <= prga_ok;
            end
            if (clr_flags) begin
                found_q <= 1'b0;
                exh_q   <= 1'b0;
            end
            if (set_found) begin
                found_q <= 1'b1;
            end
            if (set_exh) begin
                exh_q <= 1'b1;
            end
        end
    end

    // abort overrides every other event; done inputs only matter in their own RUN state
    always_comb begin
        state_d   = state_q;
        load_key  = 1'b0;
        inc_key   = 1'b0;
        latch_ok  = 1'b0;
        clr_flags = 1'b0;
        set_found = 1'b0;
        set_exh   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (start) begin
                        state_d   = ST_INIT_RUN;
                        load_key  = 1'b1;
                        clr_flags = 1'b1;
                    end
                end
                ST_INIT_RUN: if (init_done) state_d = ST_INIT_GAP;
                ST_INIT_GAP: state_d = ST_KSA_RUN;
                ST_KSA_RUN:  if (ksa_done) state_d = ST_KSA_GAP;
                ST_KSA_GAP:  state_d = ST_PRGA_RUN;
                ST_PRGA_RUN: begin
                    if (prga_done) begin
                        latch_ok = 1'b1;
                        state_d  = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (ok_q) begin
                        state_d   = ST_FOUND;
                        set_found = 1'b1;
                    end else if (key_q == KEY_MAX) begin
                        state_d = ST_EXHAUSTED;
                        set_exh = 1'b1;
                    end else begin
                        state_d = ST_INIT_RUN;
                        inc_key = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign key        = key_q;
    assign init_start = (state_q == ST_INIT_RUN);
    assign ksa_start  = (state_q == ST_KSA_RUN);
    assign prga_start = (state_q == ST_PRGA_RUN);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_FOUND) && (state_q != ST_EXHAUSTED);
    assign found      = found_q;
    assign exhausted  = exh_q;

    s_mem_mux u_mux (
        .grant      (grant_q),
        .init_addr  (init_addr),
        .init_wdata (init_wdata),
        .init_wren  (init_wren),
        .ksa_addr   (ksa_addr),
        .ksa_wdata  (ksa_wdata),
        .ksa_wren   (ksa_wren),
        .prga_addr  (prga_addr),
        .prga_wdata (prga_wdata),
        .prga_wren  (prga_wren),
        .s_address  (s_address),
        .s_data     (s_data),
        .s_wren     (s_wren)
    );

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// tb/tb_rc4_phase_sequencer.sv - scoreboard bench for rc4_phase_sequencer with randomized phase responders
module tb_rc4_phase_sequencer;

    localparam logic [23:0] KS = 24'h3FFFF0;
    localparam logic [23:0] KM = 24'h3FFFFF;

    typedef struct {
        int          kind;      // 0 init, 1 ksa, 2 prga, 3 found, 4 exhausted, 5 abort
        logic [23:0] key;
        bit          ref_done;
        bit          f;
        bit          x;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] key;
    logic        init_start, ksa_start, prga_start;
    logic [2:0]  dn = '0;
    logic        ok;
    logic [7:0]  r_addr [3];
    logic [7:0]  r_wdata [3];
    logic [2:0]  r_wren = '0;
    logic [7:0]  s_address, s_data;
    logic        s_wren, busy, found, exhausted;

    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [23:0] pass_key = KS;
    bit          iso = 1'b0;
    exp_t        exp_q[$];
    chk_t        chk_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rc4_phase_sequencer #(.KEY_WIDTH(24), .KEY_START(KS), .KEY_MAX(KM)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key(key),
        .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
        .init_done(dn[0]), .ksa_done(dn[1]), .prga_done(dn[2]), .prga_ok(ok),
        .init_addr(r_addr[0]), .ksa_addr(r_addr[1]), .prga_addr(r_addr[2]),
        .init_wdata(r_wdata[0]), .ksa_wdata(r_wdata[1]), .prga_wdata(r_wdata[2]),
        .init_wren(r_wren[0]), .ksa_wren(r_wren[1]), .prga_wren(r_wren[2]),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
        .busy(busy), .found(found), .exhausted(exhausted)
    );

    // Phase models: hold done high after a random latency until their start drops.
    initial begin
        int cnt [3];
        int lat [3];
        logic [2:0] st;
        for (int p = 0; p < 3; p++) begin
            cnt[p] = 0;
            lat[p] = 1;
            r_addr[p] = '0;
            r_wdata[p] = '0;
        end
        ok = 1'b0;
        forever begin
            @(negedge clk);
            st = {prga_start, ksa_start, init_start};
            for (int p = 0; p < 3; p++) begin
                if (!st[p]) begin
                    dn[p]  = 1'b0;
                    cnt[p] = 0;
                    lat[p] = int'($urandom_range(1, 6));
                end else if (!dn[p]) begin
                    if (cnt[p] >= lat[p]) begin
                        dn[p]    = 1'b1;
                        done_cyc = cyc;
                    end else begin
                        cnt[p]++;
                    end
                end
                r_addr[p]  = 8'($urandom);
                r_wdata[p] = 8'($urandom);
                r_wren[p]  = 1'($urandom);
            end
            if (iso) begin
                r_wren[1] = 1'b1;
                r_addr[1] = 8'h55;
            end
            ok = dn[2] ? (key == pass_key) : 1'($urandom);
        end
    end

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, x, $time);
        end
    endtask

    // Monitor: pops expectations whenever a phase start rises or busy falls.
    initial begin
        logic [2:0] prev_st = '0;
        logic [2:0] cur, rise;
        logic       prev_busy = 1'b0;
        int         cur_ph = 0;
        exp_t       e;
        chk_t       c;
        forever begin
            @(posedge clk);
            #2;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                check(c.name, c.act, c.exp);
            end
            if (!reset_n) begin
                prev_st   = '0;
                prev_busy = 1'b0;
                continue;
            end
            cur  = {prga_start, ksa_start, init_start};
            rise = cur & ~prev_st;
            if (rise != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 32'(rise), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("phase", 32'(rise), 32'(3'b001 << e.kind));
                    check("key_at_start", 32'(key), 32'(e.key));
                    check("start_latency", 32'(cyc - (e.ref_done ? done_cyc : start_cyc)),
                          e.ref_done ? 32'd2 : 32'd1);
                    cur_ph = (e.kind < 3) ? e.kind : 0;
                end
            end
            if (cur == 0) begin
                check("parked_bus", 32'({s_wren, s_address, s_data}), 32'd0);
            end else begin
                check("mux", 32'({s_wren, s_address, s_data}),
                      32'({r_wren[cur_ph], r_addr[cur_ph], r_wdata[cur_ph]}));
                check("busy_in_run", 32'(busy), 32'd1);
            end
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_end", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("end_kind", 32'(e.kind >= 3), 32'd1);
                    check("found", 32'(found), 32'(e.f));
                    check("exhausted", 32'(exhausted), 32'(e.x));
                    if (e.kind != 5) check("final_key", 32'(key), 32'(e.key));
                    else check("abort_starts", 32'(cur), 32'd0);
                end
            end
            prev_st   = cur;
            prev_busy = busy;
        end
    end

    // Expected run list: init/ksa/prga per key until the passing key or KEY_MAX.
    task automatic model_search(input logic [23:0] pk);
        logic [23:0] k = KS;
        bit first = 1'b1;
        while (1) begin
            for (int p = 0; p < 3; p++) exp_q.push_back('{p, k, !(first && p == 0), 1'b0, 1'b0});
            first = 1'b0;
            if (k == pk) begin
                exp_q.push_back('{3, k, 1'b0, 1'b1, 1'b0});
                break;
            end
            if (k == KM) begin
                exp_q.push_back('{4, k, 1'b0, 1'b0, 1'b1});
                break;
            end
            k = k + 24'd1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_cyc = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk_q.push_back('{"drain_timeout", 32'(exp_q.size()), 32'd0});
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_search(input logic [23:0] pk);
        pass_key = pk;
        model_search(pk);
        pulse_start();
        wait_drain();
    endtask

    task automatic wait_level(input int which);
        int i;
        for (i = 0; i < 500; i++) begin
            @(negedge clk);
            if ((which == 1 && ksa_start) || (which == 2 && prga_start)) break;
        end
        if (i == 500) chk_q.push_back('{"phase_wait_timeout", 32'(which), 32'd0});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_q.push_back('{"rst_busy", 32'(busy), 32'd0});
        chk_q.push_back('{"rst_key", 32'(key), 32'(KS)});
        chk_q.push_back('{"rst_starts", 32'({init_start, ksa_start, prga_start}), 32'd0});
        chk_q.push_back('{"rst_bus", 32'({s_wren, s_address, s_data}), 32'd0});
        chk_q.push_back('{"rst_flags", 32'({found, exhausted}), 32'd0});
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        iso = 1'b1;
        run_search(KS);
        iso = 1'b0;
        run_search(KS + 24'd10);
        for (int n = 0; n < 4; n++) begin
            iso = 1'($urandom);
            run_search(KS + 24'($urandom_range(0, 4)));
        end
        run_search(24'h000000);

        // start together with abort from EXHAUSTED: abort wins, flag is kept
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk_q.push_back('{"abort_keeps_exh", 32'(exhausted), 32'd1});
        chk_q.push_back('{"abort_idle_busy", 32'(busy), 32'd0});

        // abort in the middle of KSA
        pass_key = KS + 24'd2;
        model_search(pass_key);
        pulse_start();
        wait_level(1);
        exp_q.delete();
        exp_q.push_back('{5, KS, 1'b0, 1'b0, 1'b0});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_q.push_back('{"abort_ksa_start", 32'(ksa_start), 32'd0});
        chk_q.push_back('{"abort_swren", 32'(s_wren), 32'd0});
        wait_drain();
        run_search(KS + 24'd1);

        // asynchronous reset between clock edges during PRGA
        pass_key = KS + 24'd3;
        model_search(pass_key);
        pulse_start();
        wait_level(2);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk_q.push_back('{"async_busy", 32'(busy), 32'd0});
        chk_q.push_back('{"async_prga_start", 32'(prga_start), 32'd0});
        chk_q.push_back('{"async_bus", 32'({s_wren, s_address, s_data}), 32'd0});
        chk_q.push_back('{"async_key", 32'(key), 32'(KS)});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_q.push_back('{"post_reset_idle", 32'({busy, init_start}), 32'd0});
        run_search(KS + 24'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
